marker_overlay: RTL and testbench
=================================

# marker_overlay

Downstream stage of the skin-colour centroid block: consumes the per-frame centroid strobe and the pass-through video stream, smooths the centroid across frames with a shift-based exponential moving average, tracks lock/loss, and draws a crosshair marker into the RGB stream. Sits between centroid extraction and the video output encoder; video latency through the block is fixed at 2 cycles.

## Interface
- IMG_W, 720, active pixels per line
- IMG_H, 576, active lines per frame
- ARM, 8, crosshair half-length in pixels
- THICK, 1, crosshair half-thickness in pixels
- ALPHA_SHIFT, 2, EMA weight 2^-ALPHA_SHIFT
- LOST_FRAMES, 4, consecutive frames without a centroid before loss
- COLOR, 24'hFF0000, marker RGB
- clk  in  1  pixel clock; single clock domain
- rst  in  1  synchronous, active-high reset
- de, hsync, vsync  in  1 each  video timing; vsync high = frame active
- rgb_in  in  24  pixel data
- cx, cy  in  10 each  raw centroid from upstream
- c_qv  in  1  one-cycle strobe, cx/cy valid
- en_overlay  in  1  marker drawing enable (tracking runs regardless)
- de_out, hsync_out, vsync_out  out  1 each  timing delayed 2 cycles
- rgb_out  out  24  rgb_in delayed 2 cycles, or COLOR on marker pixels
- sx, sy  out  10 each  smoothed centroid
- track_ok  out  1  high in TRACK state

## Operation
- Pixel counters cur_w/cur_h: cleared while vsync==0; on de increment cur_w, wrap at IMG_W-1 and increment cur_h, cur_h wraps at IMG_H-1.
- sof = vsync rising edge (registered vsync 0, current 1).
- Capture: on c_qv, pend_x/pend_y <= cx/cy clamped to IMG_W-1/IMG_H-1; pend_v <= 1.
- At sof, pend_v cleared and FSM evaluated with the pending value:
  - LOST + pend_v: sx,sy <= pend directly; miss <= 0; -> TRACK.
  - TRACK + pend_v: sx <= sx + ((pend_x - sx) >>> ALPHA_SHIFT), same for y; 11-bit signed difference, arithmetic shift (rounds toward -inf); miss <= 0.
  - TRACK, no pend_v: miss++ (saturating); miss reaching LOST_FRAMES -> LOST; sx,sy hold.
  - LOST, no pend_v: no change.
- c_qv coincident with sof: sof consumes the old pending value; the new value is loaded and pend_v stays 1.
- Marker pixel: track_ok && en_overlay && de && ((|dw|<=THICK && |dh|<=ARM) || (|dh|<=THICK && |dw|<=ARM)), with dw=cur_w-sx, dh=cur_h-sy as 11-bit signed; no wrap, markers at borders are clipped.
- sx/sy change only at sof, so they are constant across the drawn frame.

## Timing
- Reset: all outputs 0, sx=sy=0, state LOST, miss=0, pend_v=0, counters 0, pipeline cleared.
- Stage 1: register |dw|, |dh|, delayed video. Stage 2: compare, mux rgb_out. Video latency is exactly 2 cycles for every signal.
- sx/sy/track_ok update in the cycle after sof; the first frame drawn with the new position is the one starting at that sof.
- Reset mid-frame: outputs 0 the following cycle; tracking restarts in LOST.
- LOST -> TRACK requires one sof with pend_v; TRACK -> LOST after exactly LOST_FRAMES consecutive sof edges without a preceding c_qv.

## Structure
- Shared package skin_pkg: PIX_W=10, RGB_W=24, tracker state enum {LOST, TRACK}, abs_diff11 function.
- Sub-module centroid_tracker: capture register, FSM, miss counter, EMA; outputs sx, sy, track_ok.
- Video alignment uses the existing delay module (DELAY=2, N=3) for de/hsync/vsync.

## Test plan
- Reset, 2 frames, no c_qv -> track_ok=0, rgb_out==rgb_in delayed 2, sx=sy=0.
- c_qv cx=100,cy=50 then sof -> TRACK, sx=100, sy=50; next frame pixels (92..108,49..51) and (99..101,42..58) equal COLOR, all others pass through.
- From sx=100, c_qv cx=120 per frame -> sx 105, 108, 111, 113; with cx=99 from sx=100 -> sx=99 (shift rounding).
- Lock then 4 frames without c_qv -> track_ok falls at 4th sof; 3 missed frames then c_qv -> stays TRACK, miss=0.
- c_qv cx=0,cy=0 -> marker clipped at the corner, no wrap artefacts near x=719/y=575; cx=900 clamps to sx=719 on LOST load.
- c_qv on same cycle as sof, and rst asserted mid-line -> old value used, new pending kept; outputs 0 next cycle after rst.

Source files
------------

// File: rtl/skin_pkg.sv
// Shared types and helpers for the skin-colour centroid / marker overlay path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package skin_pkg;

    localparam int PIX_W = 10;   // pixel coordinate width
    localparam int RGB_W = 24;   // packed 8:8:8 pixel

    typedef enum logic {
        LOST  = 1'b0,
        TRACK = 1'b1
    } trk_state_t;

    // Absolute distance between two unsigned coordinates. The difference is
    // formed one bit wider so it can never wrap, which keeps border markers clipped.
    function automatic logic [PIX_W:0] abs_diff11(input logic [PIX_W-1:0] a,
                                                  input logic [PIX_W-1:0] b);
        logic [PIX_W:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[PIX_W] ? (~d + 1'b1) : d;
    endfunction

endpackage

// File: rtl/centroid_tracker.sv
// Captures the raw centroid, smooths it across frames with a shift EMA and tracks lock/loss.
// Latency: sx/sy/track_ok update the cycle after sof. Backpressure: none, c_qv is always accepted.
// Ports: clk, rst, sof, c_qv/cx/cy (raw centroid strobe) -> sx, sy (smoothed), track_ok.
module centroid_tracker import skin_pkg::*; #(
    parameter int IMG_W       = 720,
    parameter int IMG_H       = 576,
    parameter int ALPHA_SHIFT = 2,
    parameter int LOST_FRAMES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sof,
    input  logic             c_qv,
    input  logic [PIX_W-1:0] cx,
    input  logic [PIX_W-1:0] cy,
    output logic [PIX_W-1:0] sx,
    output logic [PIX_W-1:0] sy,
    output logic             track_ok
);

    localparam logic [PIX_W-1:0] X_MAX    = PIX_W'(IMG_W - 1);
    localparam logic [PIX_W-1:0] Y_MAX    = PIX_W'(IMG_H - 1);
    localparam int               MISS_W   = $clog2(LOST_FRAMES + 1);
    localparam logic [MISS_W-1:0] MISS_LIM = MISS_W'(LOST_FRAMES);

    trk_state_t        state, state_nxt;
    logic [PIX_W-1:0]  pend_x, pend_y;
    logic              pend_v;
    logic [PIX_W-1:0]  sx_nxt, sy_nxt;
    logic [MISS_W-1:0] miss, miss_nxt;
    logic signed [PIX_W:0] dx, dy, dx_step, dy_step;

    // Pending centroid. A strobe coincident with sof wins over the clear: sof
    // has already consumed the old value through the FSM this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_x <= '0;
            pend_y <= '0;
            pend_v <= 1'b0;
        end else if (c_qv) begin
            pend_x <= (cx > X_MAX) ? X_MAX : cx;
            pend_y <= (cy > Y_MAX) ? Y_MAX : cy;
            pend_v <= 1'b1;
        end else if (sof) begin
            pend_v <= 1'b0;
        end
    end

    // Arithmetic shift floors toward -inf, so small negative steps still move by one.
    assign dx      = $signed({1'b0, pend_x}) - $signed({1'b0, sx});
    assign dy      = $signed({1'b0, pend_y}) - $signed({1'b0, sy});
    assign dx_step = dx >>> ALPHA_SHIFT;
    assign dy_step = dy >>> ALPHA_SHIFT;

    always_comb begin
        state_nxt = state;
        sx_nxt    = sx;
        sy_nxt    = sy;
        miss_nxt  = miss;
        if (sof) begin
            case (state)
                LOST: begin
                    if (pend_v) begin
                        sx_nxt    = pend_x;
                        sy_nxt    = pend_y;
                        miss_nxt  = '0;
                        state_nxt = TRACK;
                    end
                end
                TRACK: begin
                    if (pend_v) begin
                        sx_nxt   = sx + dx_step[PIX_W-1:0];
                        sy_nxt   = sy + dy_step[PIX_W-1:0];
                        miss_nxt = '0;
                    end else begin
                        miss_nxt = (miss == MISS_LIM) ? miss : miss + 1'b1;
                        if (miss_nxt == MISS_LIM) state_nxt = LOST;
                    end
                end
                default: state_nxt = LOST;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOST;
            sx    <= '0;
            sy    <= '0;
            miss  <= '0;
        end else begin
            state <= state_nxt;
            sx    <= sx_nxt;
            sy    <= sy_nxt;
            miss  <= miss_nxt;
        end
    end

    assign track_ok = (state == TRACK);

endmodule

// File: rtl/delay.sv
// Generic N-bit wide, DELAY-deep register pipeline with synchronous clear.
// Latency: DELAY cycles. Backpressure: none, advances every cycle.
// Ports: clk, rst (sync, active-high), d -> q.
module delay #(
    parameter int DELAY = 2,
    parameter int N     = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] pipe [DELAY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DELAY; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < DELAY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[DELAY-1];

endmodule

// File: rtl/marker_overlay.sv
// Smooths the per-frame centroid and draws a clipped crosshair into the RGB stream.
// Latency: video (de/hsync/vsync/rgb) exactly 2 cycles. Backpressure: none, streaming pixel path.
// Ports: clk, rst, de/hsync/vsync/rgb_in, cx/cy/c_qv, en_overlay -> *_out video, sx, sy, track_ok.
module marker_overlay import skin_pkg::*; #(
    parameter int               IMG_W       = 720,
    parameter int               IMG_H       = 576,
    parameter int               ARM         = 8,
    parameter int               THICK       = 1,
    parameter int               ALPHA_SHIFT = 2,
    parameter int               LOST_FRAMES = 4,
    parameter logic [RGB_W-1:0] COLOR       = 24'hFF0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             de,
    input  logic             hsync,
    input  logic             vsync,
    input  logic [RGB_W-1:0] rgb_in,
    input  logic [PIX_W-1:0] cx,
    input  logic [PIX_W-1:0] cy,
    input  logic             c_qv,
    input  logic             en_overlay,
    output logic             de_out,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic [RGB_W-1:0] rgb_out,
    output logic [PIX_W-1:0] sx,
    output logic [PIX_W-1:0] sy,
    output logic             track_ok
);

    localparam logic [PIX_W-1:0] W_LAST = PIX_W'(IMG_W - 1);
    localparam logic [PIX_W-1:0] H_LAST = PIX_W'(IMG_H - 1);
    localparam logic [PIX_W:0]   ARM_L  = (PIX_W+1)'(ARM);
    localparam logic [PIX_W:0]   THK_L  = (PIX_W+1)'(THICK);

    logic             vsync_q, sof;
    logic [PIX_W-1:0] cur_w, cur_h;
    logic [PIX_W:0]   adw_q, adh_q;
    logic [RGB_W-1:0] rgb_q;
    logic             gate_q, mark;

    assign sof = vsync & ~vsync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q <= 1'b0;
            cur_w   <= '0;
            cur_h   <= '0;
        end else begin
            vsync_q <= vsync;
            if (!vsync) begin
                cur_w <= '0;
                cur_h <= '0;
            end else if (de) begin
                if (cur_w == W_LAST) begin
                    cur_w <= '0;
                    cur_h <= (cur_h == H_LAST) ? '0 : cur_h + 1'b1;
                end else begin
                    cur_w <= cur_w + 1'b1;
                end
            end
        end
    end

    centroid_tracker #(
        .IMG_W      (IMG_W),
        .IMG_H      (IMG_H),
        .ALPHA_SHIFT(ALPHA_SHIFT),
        .LOST_FRAMES(LOST_FRAMES)
    ) u_tracker (
        .clk     (clk),
        .rst     (rst),
        .sof     (sof),
        .c_qv    (c_qv),
        .cx      (cx),
        .cy      (cy),
        .sx      (sx),
        .sy      (sy),
        .track_ok(track_ok)
    );

    // Stage 1: distances and the enable gate; stage 2: window compare and mux.
    always_ff @(posedge clk) begin
        if (rst) begin
            adw_q   <= '0;
            adh_q   <= '0;
            rgb_q   <= '0;
            gate_q  <= 1'b0;
            rgb_out <= '0;
        end else begin
            adw_q   <= abs_diff11(cur_w, sx);
            adh_q   <= abs_diff11(cur_h, sy);
            rgb_q   <= rgb_in;
            gate_q  <= track_ok & en_overlay & de;
            rgb_out <= mark ? COLOR : rgb_q;
        end
    end

    assign mark = gate_q && (((adw_q <= THK_L) && (adh_q <= ARM_L)) ||
                             ((adh_q <= THK_L) && (adw_q <= ARM_L)));

    delay #(
        .DELAY(2),
        .N    (3)
    ) u_vid_dly (
        .clk(clk),
        .rst(rst),
        .d  ({de, hsync, vsync}),
        .q  ({de_out, hsync_out, vsync_out})
    );

endmodule

// File: tb/tb_marker_overlay.sv
// Directed bench for marker_overlay: per-pixel video check against a 2-deep expectation history,
// plus hand-computed tracker values after each frame.
// Drives at negedge, samples at negedge; the video stream has no backpressure.
module tb_marker_overlay;

    localparam logic [23:0] COLOR = 24'hFF0000;

    logic        clk, rst, de, hsync, vsync, c_qv, en_overlay;
    logic [23:0] rgb_in, rgb_out;
    logic [9:0]  cx, cy, sx, sy;
    logic        de_out, hsync_out, vsync_out, track_ok;

    int n_cmp = 0;
    int n_err = 0;

    // bench model state
    logic [26:0] hist [2];
    int          hist_n = 0;
    logic        qv_req = 1'b0;
    logic [9:0]  qx_req = '0, qy_req = '0;
    logic        exp_trk = 1'b0;
    int          ex = 0, ey = 0;

    marker_overlay dut (
        .clk(clk), .rst(rst), .de(de), .hsync(hsync), .vsync(vsync), .rgb_in(rgb_in),
        .cx(cx), .cy(cy), .c_qv(c_qv), .en_overlay(en_overlay),
        .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out), .rgb_out(rgb_out),
        .sx(sx), .sy(sy), .track_ok(track_ok)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] pix(input int x, input int y);
        logic [7:0] a, b;
        a = 8'(x);
        b = 8'(y);
        return {a ^ 8'hA5, b, 8'h0F};
    endfunction

    function automatic logic want(input int x, input int y);
        int adx, ady;
        adx = (x > ex) ? x - ex : ex - x;
        ady = (y > ey) ? y - ey : ey - y;
        return exp_trk && en_overlay && (((adx <= 1) && (ady <= 8)) || ((ady <= 1) && (adx <= 8)));
    endfunction

    // One clock: check the output due from two ticks ago, then drive the next input.
    task automatic tick(input logic d, input logic h, input logic v,
                        input logic [23:0] rgb, input logic mark, input logic r);
        @(negedge clk);
        if (hist_n >= 2)
            check("vid", {5'b0, de_out, hsync_out, vsync_out, rgb_out}, {5'b0, hist[1]});
        hist[1] = hist[0];
        hist[0] = {d, h, v, (mark && d) ? COLOR : rgb};
        if (r) begin
            hist[0] = '0;
            hist[1] = '0;
            hist_n  = 2;
        end
        de = d; hsync = h; vsync = v; rgb_in = rgb; rst = r;
        c_qv = qv_req; cx = qx_req; cy = qy_req;
        qv_req = 1'b0;
    endtask

    task automatic qv_pulse(input logic [9:0] x, input logic [9:0] y);
        qv_req = 1'b1; qx_req = x; qy_req = y;
        tick(0, 0, 0, '0, 0, 0);
    endtask

    task automatic frame(input int nlines, input logic qs, input logic [9:0] qsx, input logic [9:0] qsy);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, '0, 0, 0);
        if (qs) begin
            qv_req = 1'b1; qx_req = qsx; qy_req = qsy;
        end
        tick(0, 0, 1, '0, 0, 0);   // sof
        for (int y = 0; y < nlines; y++) begin
            for (int x = 0; x < 720; x++) tick(1, 0, 1, pix(x, y), want(x, y), 0);
            for (int b = 0; b < 4; b++) tick(0, 1, 1, '0, 0, 0);
        end
        tick(0, 0, 1, '0, 0, 0);
        tick(0, 0, 1, '0, 0, 0);
    endtask

    task automatic check_trk(input string tag, input logic t, input int x, input int y);
        check({tag, "_trk"}, 32'(track_ok), 32'(t));
        check({tag, "_sx"}, 32'(sx), 32'(x));
        check({tag, "_sy"}, 32'(sy), 32'(y));
    endtask

    initial begin
        rst = 1'b1; de = 0; hsync = 0; vsync = 0; rgb_in = '0;
        cx = '0; cy = '0; c_qv = 0; en_overlay = 1'b1;

        for (int i = 0; i < 3; i++) tick(0, 0, 0, '0, 0, 1);
        tick(0, 0, 0, '0, 0, 0);
        check_trk("reset", 0, 0, 0);
        check("reset_rgb", 32'(rgb_out), 32'd0);

        // No centroid: pure pass-through
        frame(2, 0, 0, 0);
        frame(2, 0, 0, 0);
        check_trk("idle", 0, 0, 0);

        // Lock at (100,50) and draw the full crosshair region
        qv_pulse(10'd100, 10'd50);
        exp_trk = 1; ex = 100; ey = 50;
        frame(59, 0, 0, 0);
        check_trk("lock", 1, 100, 50);

        // Overlay disabled: tracking stays, pixels pass through
        en_overlay = 1'b0;
        frame(1, 0, 0, 0);
        en_overlay = 1'b1;

        // EMA toward 120
        qv_pulse(10'd120, 10'd50); frame(0, 0, 0, 0); check_trk("ema1", 1, 105, 50);
        qv_pulse(10'd120, 10'd50); frame(0, 0, 0, 0); check_trk("ema2", 1, 108, 50);
        qv_pulse(10'd120, 10'd50); frame(0, 0, 0, 0); check_trk("ema3", 1, 111, 50);
        qv_pulse(10'd120, 10'd50); frame(0, 0, 0, 0); check_trk("ema4", 1, 113, 50);

        // Loss after exactly four missed frames
        frame(0, 0, 0, 0); check_trk("miss1", 1, 113, 50);
        frame(0, 0, 0, 0); check_trk("miss2", 1, 113, 50);
        frame(0, 0, 0, 0); check_trk("miss3", 1, 113, 50);
        frame(0, 0, 0, 0); check_trk("miss4", 0, 113, 50);

        // Reload then negative step rounding: 100 -> 99
        qv_pulse(10'd100, 10'd50); frame(0, 0, 0, 0); check_trk("reload", 1, 100, 50);
        qv_pulse(10'd99, 10'd50);  frame(0, 0, 0, 0); check_trk("round", 1, 99, 50);

        // Three misses then a hit resets the miss count
        for (int i = 0; i < 3; i++) begin
            frame(0, 0, 0, 0); check_trk("pre_hit", 1, 99, 50);
        end
        qv_pulse(10'd99, 10'd50); frame(0, 0, 0, 0); check_trk("hit", 1, 99, 50);
        for (int i = 0; i < 3; i++) begin
            frame(0, 0, 0, 0); check_trk("post_hit", 1, 99, 50);
        end
        frame(0, 0, 0, 0); check_trk("post_hit_lost", 0, 99, 50);

        // Corner marker, clipped; full lines exercise x=719
        qv_pulse(10'd0, 10'd0);
        exp_trk = 1; ex = 0; ey = 0;
        frame(10, 0, 0, 0);
        check_trk("corner", 1, 0, 0);
        for (int i = 0; i < 4; i++) frame(0, 0, 0, 0);
        check_trk("corner_lost", 0, 0, 0);
        exp_trk = 0;

        // Clamp on LOST load
        qv_pulse(10'd900, 10'd600); frame(0, 0, 0, 0); check_trk("clamp", 1, 719, 575);

        // Strobe on the sof cycle: old pending used, new one kept
        qv_pulse(10'd711, 10'd575);
        frame(0, 1, 10'd10, 10'd20);
        check_trk("sof_qv_old", 1, 717, 575);
        frame(0, 0, 0, 0);
        check_trk("sof_qv_new", 1, 540, 436);

        // Reset in the middle of a line
        exp_trk = 1; ex = 540; ey = 436;
        for (int i = 0; i < 4; i++) tick(0, 0, 0, '0, 0, 0);
        tick(0, 0, 1, '0, 0, 0);
        for (int x = 0; x < 100; x++) tick(1, 0, 1, pix(x, 0), want(x, 0), 0);
        tick(1, 0, 1, pix(100, 0), 0, 1);
        exp_trk = 0;
        @(negedge clk);
        check("rst_rgb_next", 32'(rgb_out), 32'd0);
        check("rst_de_next", 32'(de_out), 32'd0);
        check_trk("rst_mid", 0, 0, 0);
        for (int x = 0; x < 50; x++) tick(1, 0, 1, pix(x, 0), 0, 0);
        check_trk("rst_after", 0, 0, 0);

        // Tracking restarts from LOST
        qv_pulse(10'd100, 10'd50); frame(0, 0, 0, 0); check_trk("relock", 1, 100, 50);

        for (int i = 0; i < 4; i++) tick(0, 0, 0, '0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
